cache_arbiter: RTL and testbench
================================

# cache_arbiter

Two-port arbiter sharing the single L2 cache port between the instruction-side L1 miss path and the data-side path (L1 D-cache behind `victim_cache`). It sits between the victim cache's `l2_*` port and the L2 cache. It grants one requester at a time and holds the grant until the L2 responds. Simultaneous requests are resolved round-robin, and a saturating contention counter is kept for performance analysis.

## Interface
- `CNT_WIDTH`, default 16: width of the contention counter.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; returns the FSM to IDLE and clears all state.
- `i_read` in 1: instruction side requests a line read.
- `i_address` in `lc3b_word`: instruction-side line address.
- `i_rdata` out `lc3b_cache_line`: line returned to the instruction side.
- `i_resp` out 1: one-cycle completion pulse to the instruction side.
- `d_read`, `d_write` in 1 each: data-side (victim cache) read or writeback request.
- `d_address` in `lc3b_word`: data-side line address.
- `d_wdata` in `lc3b_cache_line`: writeback line.
- `d_rdata` out `lc3b_cache_line`: line returned to the data side.
- `d_resp` out 1: one-cycle completion pulse to the data side.
- `l2_read`, `l2_write` out 1 each: L2 request strobes.
- `l2_address` out `lc3b_word`: L2 line address.
- `l2_wdata` out `lc3b_cache_line`: L2 write line.
- `l2_rdata` in `lc3b_cache_line`: L2 read line.
- `l2_mem_resp` in 1: L2 completion.
- `contention_count` out `CNT_WIDTH`: number of cycles on which both sides requested while the arbiter was IDLE; saturates at all-ones.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D. Reset state is IDLE.
- `last_grant` register: reset value I.
- Transitions out of IDLE:
  - only `i_read` asserted -> GRANT_I.
  - only `d_read|d_write` asserted -> GRANT_D.
  - both asserted -> grant the side opposite `last_grant`, and increment `contention_count`.
  - neither asserted -> stay in IDLE.
- On entry to a GRANT state, `last_grant` is updated to that side.
- In GRANT_I:
  - `l2_read`=`i_read`, `l2_write`=0, `l2_address`=`i_address`, `l2_wdata`=0.
- In GRANT_D:
  - `l2_write`=`d_write`.
  - `l2_read`=`d_read & ~d_write`; write wins if both are asserted.
  - `l2_address`=`d_address`, `l2_wdata`=`d_wdata`.
- In IDLE, all `l2_*` strobes are 0 and `l2_address`/`l2_wdata` are 0.
- `i_rdata` and `d_rdata` are always `l2_rdata` (pass-through).
- `i_resp` = GRANT_I & `l2_mem_resp`; `d_resp` = GRANT_D & `l2_mem_resp`. Never both; never asserted in IDLE.
- `l2_mem_resp` in a GRANT state -> IDLE next cycle.
- Abort: if the granted side drops all of its request strobes before `l2_mem_resp`, the L2 strobes fall the same cycle (combinational) and the FSM returns to IDLE next cycle.
- `l2_mem_resp` arriving while IDLE is ignored.
- Requesters hold address, data and strobes stable until their resp, and deassert the cycle after it.

## Timing
- All outputs are 0 out of reset, including while `reset` is asserted.
- `reset` mid-grant drops the L2 strobes immediately (asynchronous) and discards the in-flight response. The L2 side is reset together with the arbiter.
- Arbitration latency: a request is sampled in IDLE and L2 strobes assert on the next cycle, giving 1 cycle of added latency.
- Response path: resp and rdata are combinational from `l2_mem_resp`/`l2_rdata` in the same cycle, adding 0 cycles.
- Turnaround: after a resp there is one mandatory IDLE cycle before the next grant. Back-to-back service of the same side therefore takes at least 2 cycles plus the L2 latency.
- Fairness: under continuous dual requests, grants alternate I, D, I, D…. The first contended grant after reset goes to D.
- Counter: increments in the same clock edge as the contended grant, and holds at `2^CNT_WIDTH-1`.

## Structure
- Add `lc3b_arb_state` (enum IDLE/GRANT_I/GRANT_D) and `lc3b_arb_side` (enum I/D) to `lc3b_types`.
- Use the existing `lc3b_word` and `lc3b_cache_line` types.
- Split into one sub-module, `cache_arbiter_fsm`: state, `last_grant` and counter registers plus next-state logic. The top level holds the output muxes.

## Test plan
- Single I read, L2 responds after 3 cycles with line 0xAAAA…A:
  - `l2_read` rises 1 cycle after `i_read`, with `l2_address`=`i_address`.
  - `i_resp` pulses for exactly 1 cycle with `i_rdata`=0xAAAA…A; `d_resp` stays 0.
- D writeback plus read asserted together:
  - only `l2_write`=1 during GRANT_D, with `l2_wdata`=`d_wdata`.
  - `d_resp` pulses on `l2_mem_resp`.
- Both sides request continuously for 4 transactions after reset:
  - grant order is D, I, D, I; `contention_count`=4 (assuming the non-granted side is still asserting at each IDLE).
  - each grant is separated by exactly 1 IDLE cycle.
- `reset` asserted during GRANT_D, before `l2_mem_resp`:
  - `l2_write`, `l2_read`, `d_resp` and `contention_count` go to 0 in the same cycle.
  - after release, the first I request is serviced normally.
- Abort: `d_read` dropped mid-grant:
  - `l2_read` falls the same cycle; FSM is in IDLE next cycle.
  - a stray `l2_mem_resp` in IDLE produces no resp pulse.
- Saturation with `CNT_WIDTH`=2: 5 contended grants -> `contention_count`=3 and stays at 3.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L2 port arbiter.
// Line/word types plus arbiter state and side encodings.
package cache_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } lc3b_arb_side;

  function automatic lc3b_arb_side other_side(
    input lc3b_arb_side s
  );
    return (s == SIDE_I) ? SIDE_D : SIDE_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and L2.
// slave = arbiter view, master = environment view.
interface cache_arbiter_if
  import cache_arbiter_pkg::*;
();

  logic           i_read;
  lc3b_word       i_address;
  lc3b_cache_line i_rdata;
  logic           i_resp;

  logic           d_read;
  logic           d_write;
  lc3b_word       d_address;
  lc3b_cache_line d_wdata;
  lc3b_cache_line d_rdata;
  logic           d_resp;

  logic           l2_read;
  logic           l2_write;
  lc3b_word       l2_address;
  lc3b_cache_line l2_wdata;
  lc3b_cache_line l2_rdata;
  logic           l2_mem_resp;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata,
    input  l2_rdata, l2_mem_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output l2_read, l2_write, l2_address, l2_wdata
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata,
    output l2_rdata, l2_mem_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  l2_read, l2_write, l2_address, l2_wdata
  );

endinterface

// File: rtl/cache_arbiter_fsm.sv
// Grant FSM: state, last grant side and contention counter.
// Round-robin on contention, grant held until L2 resp or abort.
module cache_arbiter_fsm
  import cache_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic                 d_req,
  input  logic                 l2_mem_resp,
  output lc3b_arb_state        state,
  output logic [CNT_WIDTH-1:0] contention_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  lc3b_arb_state        state_q, state_d;
  lc3b_arb_side         last_q, last_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next-state, last-grant and saturating counter update
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          last_d  = other_side(last_q);
          state_d = (last_d == SIDE_I) ? GRANT_I
                                       : GRANT_D;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (i_req) begin
          last_d  = SIDE_I;
          state_d = GRANT_I;
        end else if (d_req) begin
          last_d  = SIDE_D;
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        if (l2_mem_resp || !i_req) begin
          state_d = IDLE;
        end
      end
      GRANT_D: begin
        if (l2_mem_resp || !d_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= SIDE_I;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state            = state_q;
  assign contention_count = cnt_q;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one L2 port between the I-side and D-side miss paths.
// Output muxes here; arbitration state lives in the FSM.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_arbiter_if.slave       bus,
  output logic [CNT_WIDTH-1:0] contention_count
);

  lc3b_arb_state state;
  logic          i_req;
  logic          d_req;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  cache_arbiter_fsm #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fsm (
    .clk              (clk),
    .reset            (reset),
    .i_req            (i_req),
    .d_req            (d_req),
    .l2_mem_resp      (bus.l2_mem_resp),
    .state            (state),
    .contention_count (contention_count)
  );

  // Route the granted side onto L2; strobes follow the requester
  always_comb begin
    bus.l2_read    = 1'b0;
    bus.l2_write   = 1'b0;
    bus.l2_address = '0;
    bus.l2_wdata   = '0;
    case (state)
      GRANT_I: begin
        bus.l2_read    = bus.i_read;
        bus.l2_address = bus.i_address;
      end
      GRANT_D: begin
        bus.l2_write   = bus.d_write;
        bus.l2_read    = bus.d_read & ~bus.d_write;
        bus.l2_address = bus.d_address;
        bus.l2_wdata   = bus.d_wdata;
      end
      default: begin
        bus.l2_read  = 1'b0;
        bus.l2_write = 1'b0;
      end
    endcase
  end

  assign bus.i_rdata = bus.l2_rdata;
  assign bus.d_rdata = bus.l2_rdata;
  assign bus.i_resp  = (state == GRANT_I) & bus.l2_mem_resp;
  assign bus.d_resp  = (state == GRANT_D) & bus.l2_mem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a transaction-level
// owner model checked every cycle plus literal expectations.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;
  bit          run_chk = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  cache_arbiter_if bus ();
  cache_arbiter_if bus2 ();

  cache_arbiter #(.CNT_WIDTH(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .contention_count (cnt16)
  );

  cache_arbiter #(.CNT_WIDTH(2)) dut2 (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus2),
    .contention_count (cnt2)
  );

  assign bus2.i_read      = bus.i_read;
  assign bus2.i_address   = bus.i_address;
  assign bus2.d_read      = bus.d_read;
  assign bus2.d_write     = bus.d_write;
  assign bus2.d_address   = bus.d_address;
  assign bus2.d_wdata     = bus.d_wdata;
  assign bus2.l2_rdata    = bus.l2_rdata;
  assign bus2.l2_mem_resp = bus.l2_mem_resp;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: who owns L2 (0 none, 1 I, 2 D), who got it last,
  // and how many contended grants so far.
  int owner = 0;
  int last  = 1;
  int m_cnt16 = 0;
  int m_cnt2  = 0;
  bit want_i, want_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner = 0;
      last = 1;
      m_cnt16 = 0;
      m_cnt2 = 0;
    end else begin
      want_i = bus.i_read;
      want_d = bus.d_read | bus.d_write;
      if (owner == 0) begin
        if (want_i && want_d) begin
          owner = 3 - last;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt2 < 3) m_cnt2++;
        end else if (want_i) begin
          owner = 1;
        end else if (want_d) begin
          owner = 2;
        end
        if (owner != 0) last = owner;
      end else if (bus.l2_mem_resp) begin
        owner = 0;
      end else if ((owner == 1 && !want_i) ||
                   (owner == 2 && !want_d)) begin
        owner = 0;
      end
    end
  end

  logic           e_rd, e_wr, e_ir, e_dr;
  logic [15:0]    e_addr;
  logic [127:0]   e_wd;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (run_chk) begin
      e_rd = 1'b0; e_wr = 1'b0;
      e_addr = '0; e_wd = '0;
      if (owner == 1) begin
        e_rd = bus.i_read;
        e_addr = bus.i_address;
      end else if (owner == 2) begin
        e_wr = bus.d_write;
        e_rd = bus.d_read & ~bus.d_write;
        e_addr = bus.d_address;
        e_wd = bus.d_wdata;
      end
      e_ir = (owner == 1) && bus.l2_mem_resp;
      e_dr = (owner == 2) && bus.l2_mem_resp;
      check("m_l2_read", bus.l2_read, e_rd);
      check("m_l2_write", bus.l2_write, e_wr);
      check("m_l2_address", bus.l2_address, e_addr);
      check("m_l2_wdata", bus.l2_wdata, e_wd);
      check("m_i_resp", bus.i_resp, e_ir);
      check("m_d_resp", bus.d_resp, e_dr);
      check("m_i_rdata", bus.i_rdata, bus.l2_rdata);
      check("m_d_rdata", bus.d_rdata, bus.l2_rdata);
      check("m_cnt16", cnt16, m_cnt16[15:0]);
      check("m_cnt2", cnt2, m_cnt2[1:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0;
    bus.d_address = '0; bus.d_wdata = '0;
    bus.l2_rdata = '0; bus.l2_mem_resp = 0;
    step();
    run_chk = 1'b1;
    step();
    check("rst_cnt", cnt16, 0);
    check("rst_l2_read", bus.l2_read, 0);
    reset = 1'b0;
    step();

    // Single I read, L2 answers 3 cycles later
    bus.i_read = 1; bus.i_address = 16'h1234;
    #1 check("t1_pre_rd", bus.l2_read, 0);
    step();
    check("t1_rd", bus.l2_read, 1);
    check("t1_addr", bus.l2_address, 16'h1234);
    check("t1_wr", bus.l2_write, 0);
    step(); step();
    bus.l2_mem_resp = 1; bus.l2_rdata = {8{16'hAAAA}};
    #1 check("t1_iresp", bus.i_resp, 1);
    check("t1_irdata", bus.i_rdata, {8{16'hAAAA}});
    check("t1_dresp", bus.d_resp, 0);
    step();
    bus.i_read = 0; bus.l2_mem_resp = 0; bus.l2_rdata = '0;
    #1 check("t1_iresp_off", bus.i_resp, 0);

    // D writeback and read together: write wins
    bus.d_read = 1; bus.d_write = 1;
    bus.d_address = 16'h2468;
    bus.d_wdata = 128'h0123456789abcdef_fedcba9876543210;
    step();
    check("t2_wr", bus.l2_write, 1);
    check("t2_rd", bus.l2_read, 0);
    check("t2_wdata", bus.l2_wdata,
          128'h0123456789abcdef_fedcba9876543210);
    check("t2_addr", bus.l2_address, 16'h2468);
    step();
    bus.l2_mem_resp = 1; bus.l2_rdata = {8{16'h5555}};
    #1 check("t2_dresp", bus.d_resp, 1);
    check("t2_drdata", bus.d_rdata, {8{16'h5555}});
    check("t2_iresp", bus.i_resp, 0);
    step();
    bus.d_read = 0; bus.d_write = 0; bus.d_wdata = '0;
    bus.l2_mem_resp = 0; bus.l2_rdata = '0;

    // Abort by dropping d_read, then stray resp in IDLE
    bus.d_read = 1; bus.d_address = 16'h0042;
    step();
    check("ab_rd", bus.l2_read, 1);
    step();
    bus.d_read = 0;
    #1 check("ab_drop", bus.l2_read, 0);
    step();
    bus.d_read = 1; bus.l2_mem_resp = 1;
    #1 check("ab_idle_rd", bus.l2_read, 0);
    check("ab_stray_d", bus.d_resp, 0);
    check("ab_stray_i", bus.i_resp, 0);
    step();
    bus.l2_mem_resp = 0;
    #1 check("ab_regrant", bus.l2_read, 1);
    bus.l2_mem_resp = 1;
    #1 check("ab_dresp", bus.d_resp, 1);
    step();
    bus.d_read = 0; bus.l2_mem_resp = 0;
    step();

    // Continuous dual requests after reset: D,I,D,I,D,I
    reset = 1;
    step();
    reset = 0;
    step();
    bus.i_read = 1; bus.i_address = 16'h1000;
    bus.d_read = 1; bus.d_address = 16'h2000;
    for (int k = 0; k < 6; k++) begin
      #1 check("fair_idle", bus.l2_read, 0);
      step();
      check("fair_order", bus.l2_address,
            (k % 2 == 0) ? 16'h2000 : 16'h1000);
      bus.l2_mem_resp = 1; bus.l2_rdata = 128'(k);
      #1 check("fair_dresp", bus.d_resp, (k % 2 == 0));
      check("fair_iresp", bus.i_resp, (k % 2 == 1));
      step();
      bus.l2_mem_resp = 0;
      if (k == 3) begin
        check("fair_cnt4", cnt16, 4);
        check("sat_cnt2_4", cnt2, 3);
      end
    end
    check("fair_cnt6", cnt16, 6);
    check("sat_cnt2_6", cnt2, 3);
    bus.i_read = 0; bus.d_read = 0;
    step();

    // Reset in the middle of a D grant
    reset = 1;
    step();
    reset = 0;
    step();
    bus.i_read = 1; bus.i_address = 16'h0777;
    bus.d_write = 1; bus.d_address = 16'h3000;
    bus.d_wdata = 128'hbeef;
    step();
    check("rg_wr", bus.l2_write, 1);
    check("rg_cnt", cnt16, 1);
    step();
    reset = 1; bus.l2_mem_resp = 1;
    #1 check("rg_wr_off", bus.l2_write, 0);
    check("rg_rd_off", bus.l2_read, 0);
    check("rg_dresp", bus.d_resp, 0);
    check("rg_cnt0", cnt16, 0);
    step();
    bus.i_read = 0; bus.d_write = 0; bus.l2_mem_resp = 0;
    step();
    reset = 0;
    step();
    bus.i_read = 1;
    step();
    check("rg_i_rd", bus.l2_read, 1);
    check("rg_i_addr", bus.l2_address, 16'h0777);
    bus.l2_mem_resp = 1; bus.l2_rdata = {8{16'h1357}};
    #1 check("rg_iresp", bus.i_resp, 1);
    check("rg_irdata", bus.i_rdata, {8{16'h1357}});
    step();
    bus.i_read = 0; bus.l2_mem_resp = 0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
